// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port memory arbiter.
// Contents: FSM state encoding, port index type, default tag depth and
// the owner-selection helper used by both channel FSMs.
package mem_arb_pkg;

  localparam int unsigned TAG_DEPTH_DEF = 32;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } arb_state_e;

  typedef logic port_idx_t;

  // Owner for a new burst: lone requester wins, on contention the priority port wins.
  function automatic port_idx_t pick_owner(input logic req0, input logic req1,
                                           input port_idx_t prio);
    port_idx_t owner;
    if (req0 && req1) begin
      owner = prio;
    end else if (req1) begin
      owner = 1'b1;
    end else begin
      owner = 1'b0;
    end
    return owner;
  endfunction

endpackage

// File: rtl/mem_arb_tag_fifo.sv
// Read-return tag FIFO: remembers which port issued each outstanding read beat.
// Ports: clk, rst (sync, active-high); push/push_data write a 1-bit tag;
// pop retires the head; head is first-word-fall-through; count/full/empty status.
module mem_arb_tag_fifo
  import mem_arb_pkg::*;
#(
  parameter int unsigned DEPTH = TAG_DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       push_data,
  input  logic                       pop,
  output logic                       head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DEPTH-1:0] mem;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Tag storage needs no reset: entries are only read once written.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Wrap-around pointers and occupancy count.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-port memory arbiter: round-robin burst arbitration of independent
// write and read channels onto one shared memory port, with in-order read
// return routed back to the issuing port via a tag FIFO.
// Ports: clk, rst (sync, active-high); p0_*/p1_* write and read request
// channels; mem_wr_*/mem_rd_* shared memory port; tag_cnt outstanding read
// beats; err_unexp_rd sticky flag for read data with nothing outstanding.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 512,
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned TAG_DEPTH  = TAG_DEPTH_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  // port 0 write
  input  logic                        p0_wr_vld,
  input  logic                        p0_wr_last,
  input  logic [ADDR_WIDTH-1:0]       p0_wr_addr,
  input  logic [DATA_WIDTH-1:0]       p0_wr_data,
  input  logic [DATA_WIDTH/8-1:0]     p0_wr_strb,
  output logic                        p0_wr_rdy,
  // port 1 write
  input  logic                        p1_wr_vld,
  input  logic                        p1_wr_last,
  input  logic [ADDR_WIDTH-1:0]       p1_wr_addr,
  input  logic [DATA_WIDTH-1:0]       p1_wr_data,
  input  logic [DATA_WIDTH/8-1:0]     p1_wr_strb,
  output logic                        p1_wr_rdy,
  // port 0 read
  input  logic                        p0_rd_en,
  input  logic                        p0_rd_last,
  input  logic [ADDR_WIDTH-1:0]       p0_rd_addr,
  output logic                        p0_rd_rdy,
  output logic [DATA_WIDTH-1:0]       p0_rd_data,
  output logic                        p0_rd_data_vld,
  // port 1 read
  input  logic                        p1_rd_en,
  input  logic                        p1_rd_last,
  input  logic [ADDR_WIDTH-1:0]       p1_rd_addr,
  output logic                        p1_rd_rdy,
  output logic [DATA_WIDTH-1:0]       p1_rd_data,
  output logic                        p1_rd_data_vld,
  // shared memory write port
  input  logic                        mem_wr_cmd_rdy,
  output logic [ADDR_WIDTH-1:0]       mem_wr_addr,
  output logic [DATA_WIDTH-1:0]       mem_wr_data,
  output logic [DATA_WIDTH/8-1:0]     mem_wr_datastrb,
  // shared memory read port
  input  logic                        mem_rd_cmd_rdy,
  output logic                        mem_rd_en,
  output logic [ADDR_WIDTH-1:0]       mem_rd_addr,
  input  logic [DATA_WIDTH-1:0]       mem_rd_data,
  input  logic                        mem_rd_data_vld,
  // status
  output logic [$clog2(TAG_DEPTH):0]  tag_cnt,
  output logic                        err_unexp_rd
);

  localparam int unsigned MASK_WIDTH = DATA_WIDTH / 8;

  arb_state_e wr_state;
  port_idx_t  wr_owner;
  port_idx_t  wr_prio;
  arb_state_e rd_state;
  port_idx_t  rd_owner;
  port_idx_t  rd_prio;

  logic                  wr_busy;
  logic                  wr_own_vld;
  logic                  wr_own_last;
  logic                  wr_beat;
  logic                  rd_busy;
  logic                  rd_own_en;
  logic                  rd_own_last;
  logic                  rd_beat;
  logic                  tag_head;
  logic                  tag_full;
  logic                  tag_empty;
  logic                  tag_pop;

  // ---------------- write channel ----------------
  assign wr_busy     = (wr_state == ST_BURST);
  assign wr_own_vld  = wr_owner ? p1_wr_vld  : p0_wr_vld;
  assign wr_own_last = wr_owner ? p1_wr_last : p0_wr_last;
  assign wr_beat     = wr_busy && wr_own_vld && mem_wr_cmd_rdy;

  assign p0_wr_rdy = wr_busy && (wr_owner == 1'b0) && mem_wr_cmd_rdy;
  assign p1_wr_rdy = wr_busy && (wr_owner == 1'b1) && mem_wr_cmd_rdy;

  // Zero strobe marks a non-write cycle, so it also covers idle and owner bubbles.
  assign mem_wr_addr     = wr_owner ? p1_wr_addr : p0_wr_addr;
  assign mem_wr_data     = wr_owner ? p1_wr_data : p0_wr_data;
  assign mem_wr_datastrb = (wr_busy && wr_own_vld) ?
                           (wr_owner ? p1_wr_strb : p0_wr_strb) : MASK_WIDTH'(0);

  // Write FSM: grant latched in IDLE, held until the owner's last beat is taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state <= ST_IDLE;
      wr_owner <= 1'b0;
      wr_prio  <= 1'b0;
    end else begin
      case (wr_state)
        ST_IDLE: begin
          if (p0_wr_vld || p1_wr_vld) begin
            wr_state <= ST_BURST;
            wr_owner <= pick_owner(p0_wr_vld, p1_wr_vld, wr_prio);
          end
        end
        ST_BURST: begin
          if (wr_beat && wr_own_last) begin
            wr_state <= ST_IDLE;
            wr_prio  <= ~wr_owner;
          end
        end
        default: wr_state <= ST_IDLE;
      endcase
    end
  end

  // ---------------- read channel ----------------
  assign rd_busy     = (rd_state == ST_BURST);
  assign rd_own_en   = rd_owner ? p1_rd_en   : p0_rd_en;
  assign rd_own_last = rd_owner ? p1_rd_last : p0_rd_last;

  // Stop issuing when every tag slot is in use; the burst simply stalls.
  assign mem_rd_en   = rd_busy && rd_own_en && !tag_full;
  assign mem_rd_addr = rd_owner ? p1_rd_addr : p0_rd_addr;
  assign rd_beat     = mem_rd_en && mem_rd_cmd_rdy;

  assign p0_rd_rdy = rd_beat && (rd_owner == 1'b0);
  assign p1_rd_rdy = rd_beat && (rd_owner == 1'b1);

  // Read FSM: same grant rules as the write side, independent priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state <= ST_IDLE;
      rd_owner <= 1'b0;
      rd_prio  <= 1'b0;
    end else begin
      case (rd_state)
        ST_IDLE: begin
          if (p0_rd_en || p1_rd_en) begin
            rd_state <= ST_BURST;
            rd_owner <= pick_owner(p0_rd_en, p1_rd_en, rd_prio);
          end
        end
        ST_BURST: begin
          if (rd_beat && rd_own_last) begin
            rd_state <= ST_IDLE;
            rd_prio  <= ~rd_owner;
          end
        end
        default: rd_state <= ST_IDLE;
      endcase
    end
  end

  // ---------------- read return routing ----------------
  mem_arb_tag_fifo #(
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rd_beat),
    .push_data (rd_owner),
    .pop       (tag_pop),
    .head      (tag_head),
    .count     (tag_cnt),
    .full      (tag_full),
    .empty     (tag_empty)
  );

  // Returned data is in issue order, so the FIFO head names its owner.
  assign tag_pop        = mem_rd_data_vld && !tag_empty;
  assign p0_rd_data_vld = tag_pop && (tag_head == 1'b0);
  assign p1_rd_data_vld = tag_pop && (tag_head == 1'b1);
  assign p0_rd_data     = mem_rd_data;
  assign p1_rd_data     = mem_rd_data;

  // Sticky: data arrived with nothing outstanding.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_unexp_rd <= 1'b0;
    end else if (mem_rd_data_vld && tag_empty) begin
      err_unexp_rd <= 1'b1;
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 DATA_WIDTH, 512, data bus width.
REQ-002 ADDR_WIDTH, 64, byte address width.
REQ-003 MASK_WIDTH, DATA_WIDTH/8, strobe width and per-beat address increment.
REQ-004 TAG_DEPTH, 32, maximum outstanding read beats (power of 2).
REQ-005 clk  in  1  clock; reset rst, synchronous, active-high; all logic on rising clk.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 pN_wr_vld/pN_wr_last  in  1 each  write beat valid / last beat of burst, N in {0,1}.
REQ-008 pN_wr_addr/pN_wr_data/pN_wr_strb  in  ADDR_WIDTH/DATA_WIDTH/MASK_WIDTH  write beat payload.
REQ-009 pN_wr_rdy  out  1  write beat accepted this cycle when pN_wr_vld high.
REQ-010 pN_rd_en/pN_rd_last  in  1 each  read beat request / last beat of burst.
REQ-011 pN_rd_addr  in  ADDR_WIDTH  read beat address.
REQ-012 pN_rd_rdy  out  1  read beat request accepted.
REQ-013 pN_rd_data/pN_rd_data_vld  out  DATA_WIDTH/1  routed read data and valid.
REQ-014 mem_wr_cmd_rdy  in  1; mem_wr_addr/mem_wr_data/mem_wr_datastrb  out  ADDR/DATA/MASK_WIDTH  shared write port.
REQ-015 mem_rd_cmd_rdy  in  1; mem_rd_en  out  1; mem_rd_addr  out  ADDR_WIDTH  shared read command port.
REQ-016 mem_rd_data/mem_rd_data_vld  in  DATA_WIDTH/1  in-order read return, no backpressure.
REQ-017 tag_cnt  out  $clog2(TAG_DEPTH)+1  outstanding read beats; err_unexp_rd  out  1  sticky error.

Function
REQ-018 Write and read channels arbitrate independently, each FSM states IDLE and BURST plus owner bit.
REQ-019 IDLE: any pN_wr_vld -> BURST next cycle, owner = requester; both request -> owner = port not granted last (wr_prio toggles per completed burst; reset prio = port 0).
REQ-020 IDLE: all pN_wr_rdy low, mem_wr_datastrb all-zero (zero strobe = no write).
REQ-021 BURST: mem_wr_addr/data from owner; mem_wr_datastrb = owner strb when owner wr_vld else zero; owner wr_rdy = mem_wr_cmd_rdy; non-owner wr_rdy low.
REQ-022 BURST -> IDLE on accepted beat (vld && rdy) with wr_last; single-beat burst therefore occupies 2 cycles minimum (1 IDLE bubble).
REQ-023 Read FSM identical rules with rd_en/rd_last/rd_prio; BURST: mem_rd_en = owner rd_en && !tag_full; owner rd_rdy = mem_rd_cmd_rdy && mem_rd_en.
REQ-024 Each accepted read beat pushes owner bit into tag FIFO; tag_full when tag_cnt == TAG_DEPTH blocks further mem_rd_en, FSM stays in BURST.
REQ-025 mem_rd_data_vld pops tag FIFO same cycle; pN_rd_data_vld = vld && head==N, combinational (0 latency); pN_rd_data = mem_rd_data for both ports.
REQ-026 Simultaneous push and pop: tag_cnt unchanged, data order preserved; push at full never occurs; pop when full allowed.
REQ-027 mem_rd_data_vld with tag FIFO empty: no pN_rd_data_vld, no pop, err_unexp_rd set until rst.
REQ-028 Arbiter never interleaves beats of different owners within a burst on either channel.

Reset
REQ-029 rst: both FSMs IDLE, prio = port 0, tag FIFO empty, tag_cnt 0, err_unexp_rd 0, all rdy/vld/en outputs 0, datastrb zero.
REQ-030 rst mid-burst aborts burst without completion; read data returning after rst is treated per REQ-027.

Structure
REQ-031 Shared package mem_arb_pkg: FSM state encoding (IDLE, BURST), port index type, TAG_DEPTH default.
REQ-032 One sub-module mem_arb_tag_fifo: 1-bit wide, TAG_DEPTH deep, FWFT, count/full/empty outputs, wrap-around pointers.

Verification
REQ-033 p0 4-beat write, mem_wr_cmd_rdy=1 -> IDLE 1 cycle, 4 consecutive p0_wr_rdy, mem_wr_addr = base+0/64/128/192, FSM IDLE after beat 4.
REQ-034 p0 and p1 both request writes from reset -> p0 burst first, then p1, then p0 again (round-robin alternation).
REQ-035 p1 8-beat read, memory returns data 3 cycles later -> 8 p1_rd_data_vld, none on p0, tag_cnt peaks at ≤3 and returns 0.
REQ-036 mem_rd_data_vld held 0, p0 issues 40 read beats -> 32 accepted, mem_rd_en low at tag_cnt 32; one pop -> exactly one more accepted.
REQ-037 mem_rd_data_vld with empty FIFO -> err_unexp_rd=1 next cycle, stays 1 until rst.
REQ-038 rst asserted mid 4-beat p1 write -> next cycle all outputs at REQ-029 values; subsequent p0 request granted.
